// File: rtl/instr_to_imm.sv
// instr_to_imm: registered immediate generator for the RV64 decode stage.
// Takes a raw instruction word and an immediate-format select (ExtOp) and
// returns the XLEN-bit sign/zero-extended immediate one cycle later with a
// valid flag.
// Optional build macro INSTRTOIMM_TYPE_CHECK_EN adds ext_err_o, which flags
// an ExtOp that is not legal for the instruction's opcode.
module instr_to_imm #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [2:0]      ExtOp,
`ifdef INSTRTOIMM_TYPE_CHECK_EN
    output logic            ext_err_o,
`endif
    output logic            valid_o,
    output logic [XLEN-1:0] imm
);

    // Immediate format encodings driven by the decode controller.
    localparam logic [2:0] EXT_I     = 3'd0;
    localparam logic [2:0] EXT_U     = 3'd1;
    localparam logic [2:0] EXT_S     = 3'd2;
    localparam logic [2:0] EXT_B     = 3'd3;
    localparam logic [2:0] EXT_J     = 3'd4;
    localparam logic [2:0] EXT_SHAMT = 3'd5;
    localparam logic [2:0] EXT_ZIMM  = 3'd6;
    localparam logic [2:0] EXT_ZERO  = 3'd7;

    // The immediate is always built at 64 bits; XLEN=32 simply keeps the
    // low half, which matches the same formulas truncated to 32 bits.
    logic [63:0]     w_imm_full;
    logic            r_valid;
    logic [XLEN-1:0] r_imm;

    // Select and extend the immediate field for the requested format.
    always_comb begin
        w_imm_full = 64'd0;
        case (ExtOp)
            EXT_I:     w_imm_full = {{52{instr_i[31]}}, instr_i[31:20]};
            EXT_U:     w_imm_full = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
            EXT_S:     w_imm_full = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            EXT_B:     w_imm_full = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                                     instr_i[30:25], instr_i[11:8], 1'b0};
            EXT_J:     w_imm_full = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                     instr_i[20], instr_i[30:21], 1'b0};
            EXT_SHAMT: w_imm_full = {58'd0, instr_i[25:20]};
            EXT_ZIMM:  w_imm_full = {59'd0, instr_i[19:15]};
            EXT_ZERO:  w_imm_full = 64'd0;
            default:   w_imm_full = 64'd0;
        endcase
    end

    // Output register: reset clears, a valid request loads, idle holds imm.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_imm   <= '0;
        end else if (valid_i) begin
            r_valid <= 1'b1;
            r_imm   <= w_imm_full[XLEN-1:0];
        end else begin
            r_valid <= 1'b0;
            r_imm   <= r_imm;
        end
    end

    assign valid_o = r_valid;
    assign imm     = r_imm;

`ifdef INSTRTOIMM_TYPE_CHECK_EN
    // Returns 1 when ext_op is not a legal immediate format for opcode.
    function automatic logic f_ext_mismatch(input logic [2:0] ext_op,
                                            input logic [6:0] opcode);
        logic bad;
        case (ext_op)
            EXT_I: begin
                case (opcode)
                    7'b0010011, 7'b0000011, 7'b1100111,
                    7'b0011011, 7'b1110011: bad = 1'b0;
                    default:                bad = 1'b1;
                endcase
            end
            EXT_U: begin
                case (opcode)
                    7'b0110111, 7'b0010111: bad = 1'b0;
                    default:                bad = 1'b1;
                endcase
            end
            EXT_S:     bad = (opcode != 7'b0100011);
            EXT_B:     bad = (opcode != 7'b1100011);
            EXT_J:     bad = (opcode != 7'b1101111);
            EXT_SHAMT: begin
                case (opcode)
                    7'b0010011, 7'b0011011: bad = 1'b0;
                    default:                bad = 1'b1;
                endcase
            end
            EXT_ZIMM:  bad = (opcode != 7'b1110011);
            EXT_ZERO:  bad = 1'b0;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

    logic w_mismatch;
    logic r_ext_err;

    // Format/opcode legality check for the current request.
    always_comb begin
        w_mismatch = f_ext_mismatch(ExtOp, instr_i[6:0]);
    end

    // Error flag registered alongside valid_o so both refer to the same result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_err <= 1'b0;
        end else begin
            r_ext_err <= valid_i & w_mismatch;
        end
    end

    assign ext_err_o = r_ext_err;
`endif

endmodule

// File: tb/tb_instr_to_imm.sv
// tb_instr_to_imm: scoreboard bench for instr_to_imm (XLEN=64).
module tb_instr_to_imm;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] instr_i;
    logic [2:0]  ext_op;
    logic        valid_o;
    logic [63:0] imm;
`ifdef INSTRTOIMM_TYPE_CHECK_EN
    logic        ext_err_o;
`endif

    always #5 clk = ~clk;

    instr_to_imm #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .instr_i   (instr_i),
        .ExtOp     (ext_op),
`ifdef INSTRTOIMM_TYPE_CHECK_EN
        .ext_err_o (ext_err_o),
`endif
        .valid_o   (valid_o),
        .imm       (imm)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] last_imm = 64'd0;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Reference immediate built with signed shifts rather than field concatenation.
    function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] op);
        logic [63:0]        u;
        logic signed [63:0] s;
        logic [63:0]        m;
        u = {32'd0, ins};
        s = $signed({{32{ins[31]}}, ins});
        case (op)
            3'd0: m = 64'(s >>> 20);
            3'd1: m = 64'((s >>> 12) <<< 12);
            3'd2: m = 64'((s >>> 25) <<< 5) | ((u >> 7) & 64'h1F);
            3'd3: m = 64'((s >>> 31) <<< 12) | (((u >> 7) & 64'h1) << 11)
                    | (((u >> 25) & 64'h3F) << 5) | (((u >> 8) & 64'hF) << 1);
            3'd4: m = 64'((s >>> 31) <<< 20) | (((u >> 12) & 64'hFF) << 12)
                    | (((u >> 20) & 64'h1) << 11) | (((u >> 21) & 64'h3FF) << 1);
            3'd5: m = (u >> 20) & 64'h3F;
            3'd6: m = (u >> 15) & 64'h1F;
            default: m = 64'd0;
        endcase
        return m;
    endfunction

    // Reference legality check: 1 means ExtOp does not fit the opcode.
    function automatic logic model_err(input logic [31:0] ins, input logic [2:0] op);
        logic [6:0] o;
        o = ins[6:0];
        case (op)
            3'd0: return !(o == 7'h13 || o == 7'h03 || o == 7'h67 || o == 7'h1B || o == 7'h73);
            3'd1: return !(o == 7'h37 || o == 7'h17);
            3'd2: return o != 7'h23;
            3'd3: return o != 7'h63;
            3'd4: return o != 7'h6F;
            3'd5: return !(o == 7'h13 || o == 7'h1B);
            3'd6: return o != 7'h73;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle, push the expectation, then check outputs after the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] ins,
                        input logic [2:0] op, input logic [63:0] e_imm,
                        input logic e_err, input string tag);
        exp_t e;
        @(negedge clk);
        rst     = r;
        valid_i = v;
        instr_i = ins;
        ext_op  = op;
        if (!r && v) begin
            e.imm = e_imm;
            e.err = e_err;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_val({tag, "/valid"}, {63'd0, valid_o}, {63'd0, (!r && v)});
        if (r) begin
            last_imm = 64'd0;
            check_val({tag, "/rst_imm"}, imm, 64'd0);
`ifdef INSTRTOIMM_TYPE_CHECK_EN
            check_val({tag, "/rst_err"}, {63'd0, ext_err_o}, 64'd0);
`endif
        end else if (valid_o) begin
            if (sb_q.size() == 0) begin
                check_val({tag, "/sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val({tag, "/imm"}, imm, e.imm);
                last_imm = e.imm;
`ifdef INSTRTOIMM_TYPE_CHECK_EN
                check_val({tag, "/err"}, {63'd0, ext_err_o}, {63'd0, e.err});
`endif
            end
        end else begin
            check_val({tag, "/hold"}, imm, last_imm);
`ifdef INSTRTOIMM_TYPE_CHECK_EN
            check_val({tag, "/idle_err"}, {63'd0, ext_err_o}, 64'd0);
`endif
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        instr_i = 32'd0;
        ext_op  = 3'd0;

        // Reset dominates a simultaneous request.
        step(1'b1, 1'b1, 32'hFFF00093, 3'd0, 64'd0, 1'b0, "rst");
        step(1'b0, 1'b1, 32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, "addi");
        step(1'b0, 1'b1, 32'hFE20AE23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0, "sw");
        step(1'b0, 1'b1, 32'h800000B7, 3'd1, 64'hFFFFFFFF80000000, 1'b0, "lui");
        step(1'b0, 1'b1, 32'h00000463, 3'd3, 64'h0000000000000008, 1'b0, "beq");
        step(1'b0, 1'b1, 32'hFFDFF06F, 3'd4, 64'hFFFFFFFFFFFFFFFC, 1'b0, "jal");
        step(1'b0, 1'b1, 32'h300FD0F3, 3'd6, 64'd31, 1'b0, "csrrwi");
        step(1'b0, 1'b1, 32'hFFFFFFFF, 3'd7, 64'd0, 1'b0, "zero");
        step(1'b0, 1'b1, 32'h03F09093, 3'd5, 64'd63, 1'b0, "slli");
        step(1'b0, 1'b0, 32'hFFF00093, 3'd0, 64'd0, 1'b0, "idle1");
        step(1'b0, 1'b0, 32'h800000B7, 3'd1, 64'd0, 1'b0, "idle2");
        step(1'b0, 1'b1, 32'h00100093, 3'd1, 64'h0000000000100000, 1'b1, "err_u");
        step(1'b0, 1'b1, 32'h00100093, 3'd0, 64'd1, 1'b0, "err_i");

        // Random mix of formats, instructions and idle cycles.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ri;
            logic [2:0]  ro;
            logic        rv;
            ri = $urandom;
            ro = 3'($urandom_range(0, 7));
            rv = ($urandom_range(0, 3) != 0);
            step(1'b0, rv, ri, ro, model_imm(ri, ro), model_err(ri, ro), "rand");
        end

        // Mid-stream reset drops the request and clears imm, then idle holds 0.
        step(1'b1, 1'b1, 32'h800000B7, 3'd1, 64'd0, 1'b0, "rst2");
        step(1'b0, 1'b0, 32'hFFF00093, 3'd0, 64'd0, 1'b0, "idle3");

        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_to_imm.md
Name: instr_to_imm

Overview:
- Registered immediate generator for the ysyx_220053 RV64 decode stage.
- Takes a raw 32-bit instruction and an immediate-format select (ExtOp) from the decode controller.
- Produces the sign- or zero-extended XLEN-bit immediate one cycle later, with a valid flag.
- Feeds the EXU operand muxes alongside the register-file read data.

Parameters:
- XLEN, 64, width of the output immediate; legal values are 32 or 64; all extension is to XLEN bits.

Ports:
- clk      input   1     system clock; all state updates on rising edge
- rst      input   1     synchronous reset, active-high
- valid_i  input   1     instr_i/ExtOp are valid this cycle
- instr_i  input   32    raw RISC-V instruction word
- ExtOp    input   3     immediate format select (encoding below)
- valid_o  output  1     imm holds a freshly generated result
- imm      output  XLEN  generated immediate, registered

Behaviour:
- Reset:
  - On a rising clk edge with rst=1: imm <= 0, valid_o <= 0.
  - rst has priority over valid_i.
  - A transaction presented in the same cycle as rst is dropped.
- Latency: exactly 1 cycle.
  - valid_i=1 at edge N gives valid_o=1 and imm=result after edge N.
  - No backpressure.
  - Back-to-back valid_i every cycle yields one result per cycle.
- When valid_i=0: valid_o <= 0 next cycle and imm holds its last value (not cleared).
- ExtOp encoding. sext = sign-extend from the top bit shown; zext = zero-extend to XLEN.
  - 0 I:     sext(instr[31:20])
  - 1 U:     sext({instr[31:12], 12'b0}); bit 31 is replicated into [XLEN-1:32]
  - 2 S:     sext({instr[31:25], instr[11:7]})
  - 3 B:     sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - 4 J:     sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - 5 SHAMT: zext(instr[25:20]); 6-bit RV64 shift amount
  - 6 ZIMM:  zext(instr[19:15]); CSR immediate
  - 7 ZERO:  all zeros
- All 8 codes are defined; there is no X or hold behaviour for any ExtOp value.
- The generation logic is purely combinational from instr_i/ExtOp into the output register. No dependence on previous instructions.
- When XLEN=32, the same formulas apply, truncated or extended to 32 bits.

Optional Feature:
- Macro: INSTRTOIMM_TYPE_CHECK_EN.
- When defined, adds port ext_err_o (output, 1 bit), registered with the same timing as valid_o and reset to 0.
- ext_err_o <= valid_i & mismatch, where mismatch is set when ExtOp is not legal for opcode instr[6:0]:
  - I:     0010011, 0000011, 1100111, 0011011, 1110011
  - U:     0110111, 0010111
  - S:     0100011
  - B:     1100011
  - J:     1101111
  - SHAMT: 0010011, 0011011
  - ZIMM:  1110011
  - ZERO:  any opcode
- imm is still generated normally on error.
- When the macro is undefined: port absent, no check logic.

Test Plan:
- Reset: hold rst=1 with valid_i=1, instr=0xFFF00093, ExtOp=0 -> valid_o=0, imm=0; release rst -> next valid cycle gives imm=0xFFFFFFFFFFFFFFFF.
- I and S formats: addi x1,x0,-1 (0xFFF00093, ExtOp=0) -> imm=0xFFFFFFFFFFFFFFFF; sw x2,-4(x1) (0xFE20AE23, ExtOp=2) on the next cycle -> imm=0xFFFFFFFFFFFFFFFC; valid_o high both cycles.
- U format sign extension: lui x1,0x80000 (0x800000B7, ExtOp=1) -> imm=0xFFFFFFFF80000000.
- Branch and jump: beq x0,x0,+8 (0x00000463, ExtOp=3) -> imm=0x8; jal x0,-4 (0xFFDFF06F, ExtOp=4) -> imm=0xFFFFFFFFFFFFFFFC.
- Zero-extend formats and hold:
  - slli x1,x1,63 (0x03F09093, ExtOp=5) -> imm=63.
  - csrrwi with instr[19:15]=31 (ExtOp=6) -> imm=31.
  - ExtOp=7 -> imm=0.
  - Then valid_i=0 -> valid_o=0 and imm unchanged.
- With INSTRTOIMM_TYPE_CHECK_EN defined:
  - instr=0x00100093 with ExtOp=1 -> ext_err_o=1, imm=0x0000000000100000.
  - Same instr with ExtOp=0 -> ext_err_o=0, imm=1.
